_skid_buffer: RTL and testbench

//   Two-entry elastic pipeline stage with a valid/ready handshake on both sides.

---
 rtl/constants.sv | 19 +
 rtl/_skid_buffer.sv | 94 +++++++++
 tb/tb__skid_buffer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/constants.sv
`default_nettype none
// ============================================================================
//  Module      : constants (package)
//  Description : Shared word width and skid-buffer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package constants;

    localparam int WORD_LENGTH = 32;

    // Numeric values double as the occupancy count (0, 1, 2 words).
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

endpackage : constants
`default_nettype wire

// File: rtl/_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : _skid_buffer
//  Description : Two-entry elastic pipeline stage with valid/ready handshakes.
//                in_ready and out_valid decode only registered state, so a
//                downstream stall never reaches upstream combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module _skid_buffer
    import constants::*;
#(
    parameter int n = WORD_LENGTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] out_data,
    output logic [1:0]   count
);

    skid_state_t  state_q, state_d;
    logic [n-1:0] main_q,  main_d;
    logic [n-1:0] skid_q,  skid_d;
    logic         w_ix;
    logic         w_ox;

    // Outputs depend on state_q alone: no path from out_ready or in_valid.
    assign out_valid = (state_q != SKID_EMPTY);
    assign in_ready  = (state_q != SKID_FULL);
    assign count     = 2'(state_q);
    assign out_data  = main_q;

    assign w_ix = in_valid & in_ready;
    assign w_ox = out_valid & out_ready;

    // State register with main and skid data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SKID_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next-state and data-path selection; flush overrides every transfer.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Data registers keep stale contents; out_valid=0 hides them.
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (w_ix) begin
                        state_d = SKID_BUSY;
                        main_d  = in_data;
                    end
                end
                SKID_BUSY: begin
                    case ({w_ix, w_ox})
                        2'b11: main_d = in_data;
                        2'b10: begin
                            state_d = SKID_FULL;
                            skid_d  = in_data;
                        end
                        2'b01: state_d = SKID_EMPTY;
                        default: state_d = SKID_BUSY;
                    endcase
                end
                SKID_FULL: begin
                    // in_ready is low here, so only the drain path applies.
                    if (w_ox) begin
                        state_d = SKID_BUSY;
                        main_d  = skid_q;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

endmodule : _skid_buffer
`default_nettype wire

// File: tb/tb__skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb__skid_buffer
//  Description : Self-checking bench for _skid_buffer against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb__skid_buffer;

    localparam int c_W = 32;

    logic           clk;
    logic           rst_n;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [c_W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [c_W-1:0] out_data;
    logic [1:0]     count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the buffer is simply an ordered list of at most 2 words.
    logic [c_W-1:0] model_q[$];

    _skid_buffer #(.n(c_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output word must not change while the consumer is stalling it.
    a_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !flush) |=> $stable(out_data));

    a_count : assert property (@(posedge clk) disable iff (!rst_n) count <= 2'd2);

    task automatic check_eq(input string tag, input logic [c_W-1:0] obs,
                            input logic [c_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every DUT output with what the word list implies.
    task automatic check_outputs(input string tag);
        int sz;
        sz = model_q.size();
        check_eq({tag, ".count"},     32'(count),     32'(sz));
        check_eq({tag, ".in_ready"},  32'(in_ready),  32'(sz < 2));
        check_eq({tag, ".out_valid"}, 32'(out_valid), 32'(sz > 0));
        if (sz > 0)
            check_eq({tag, ".out_data"}, out_data, model_q[0]);
    endtask

    // One clock: check pre-edge outputs, drive inputs, advance model on the edge.
    task automatic cycle(input string tag, input logic iv, input logic [c_W-1:0] d,
                         input logic ordy, input logic fl);
        logic ix, ox;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        check_outputs(tag);
        ix = iv && (model_q.size() < 2);
        ox = ordy && (model_q.size() > 0);
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (ox) void'(model_q.pop_front());
            if (ix) model_q.push_back(d);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs("reset");
        check_eq("reset.out_data", out_data, 32'h0);
        rst_n = 1'b1;

        // Async reset while two words are buffered: must clear without an edge.
        cycle("t1_fill", 1'b1, 32'h11, 1'b0, 1'b0);
        cycle("t1_fill", 1'b1, 32'h22, 1'b0, 1'b0);
        check_outputs("t1_full");
        #2;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        check_eq("t1_async.out_valid", 32'(out_valid), 32'h0);
        check_eq("t1_async.in_ready",  32'(in_ready),  32'h1);
        check_eq("t1_async.count",     32'(count),     32'h0);
        check_eq("t1_async.out_data",  out_data,       32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming at one word per cycle.
        cycle("t2", 1'b1, 32'h1, 1'b1, 1'b0);
        cycle("t2", 1'b1, 32'h2, 1'b1, 1'b0);
        cycle("t2", 1'b1, 32'h3, 1'b1, 1'b0);
        cycle("t2", 1'b0, 32'h0, 1'b1, 1'b0);
        cycle("t2", 1'b0, 32'h0, 1'b1, 1'b0);

        // Stall, fill, ignored 0xC, drain; then 0xD offered on the drain edge.
        cycle("t3", 1'b1, 32'hA, 1'b0, 1'b0);
        cycle("t3", 1'b1, 32'hB, 1'b0, 1'b0);
        cycle("t3", 1'b1, 32'hC, 1'b0, 1'b0);
        cycle("t4", 1'b1, 32'hD, 1'b1, 1'b0);
        cycle("t4", 1'b1, 32'hD, 1'b1, 1'b0);
        cycle("t4", 1'b0, 32'h0, 1'b1, 1'b0);
        cycle("t4", 1'b0, 32'h0, 1'b1, 1'b0);

        // Flush while full with a same-cycle push of 0xE.
        cycle("t5", 1'b1, 32'h51, 1'b0, 1'b0);
        cycle("t5", 1'b1, 32'h52, 1'b0, 1'b0);
        cycle("t5", 1'b1, 32'hE,  1'b0, 1'b1);
        cycle("t5", 1'b0, 32'h0,  1'b1, 1'b0);
        check_eq("t5.flushed_count", 32'(count), 32'h0);

        // Random traffic with rare flushes.
        for (int i = 0; i < 10000; i++) begin
            cycle("rand", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 63) == 0));
        end
        cycle("final", 1'b0, 32'h0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb__skid_buffer
`default_nettype wire
